// File: rtl/dm_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dm_pipe_pkg
// Shared definitions for the pipelined data-memory block:
//   - load/store op encodings carried on req_op
//   - FSM state type and its two states (memory clear, normal operation)
//   - legal bounds for the LATENCY parameter
//   - the per-stage payload record carried down the response pipeline
// -----------------------------------------------------------------------------
package dm_pipe_pkg;

    // Op encodings on req_op
    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    // Controller states
    typedef logic [0:0] state_t;
    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Accept-to-response latency bounds
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    // Payload of one pipeline stage
    typedef struct packed {
        logic        err;
        logic [2:0]  op;
        logic [1:0]  lane;
        logic [31:0] pc;
        logic [31:0] word;
    } stage_t;

endpackage

// File: rtl/dm_ext.sv
// -----------------------------------------------------------------------------
// dm_ext
// Combinational load formatter: picks the byte/half lane out of a 32-bit
// memory word and sign- or zero-extends it according to the load op.
// Store ops produce 0.
// Ports:
//   i_op    in  3   op encoding (see dm_pipe_pkg)
//   i_lane  in  2   byte address bits [1:0] of the access
//   i_word  in  32  raw memory word
//   o_data  out 32  extended load result
// -----------------------------------------------------------------------------
module dm_ext
    import dm_pipe_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no
        // path through the case statements can infer a latch.
        w_byte = i_word[7:0];
        case (i_lane)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase

        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        o_data = '0;
        case (i_op)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'h0, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'h0, w_half};
            OP_LW:   o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/dm_pipe.sv
// -----------------------------------------------------------------------------
// dm_pipe
// Pipelined 32-bit data memory with byte/half/word loads and stores.
// After reset the array is cleared one word per cycle (INIT); then requests
// are accepted one per cycle (RUN). Stores write at the acceptance edge;
// loads read at the acceptance edge and the result travels through a
// LATENCY-deep register pipeline. A request accepted at edge k can be
// consumed at edge k+LATENCY at the earliest (response visible after edge
// k+LATENCY-1). A stalled response freezes the whole pipeline.
// Ports:
//   clk         in  1   clock, rising edge
//   reset       in  1   asynchronous, active-low reset
//   req_valid   in  1   request present
//   req_ready   out 1   request accepted on req_valid && req_ready
//   req_op      in  3   op (lb lbu lh lhu lw sb sh sw)
//   req_addr    in  32  byte address
//   req_wdata   in  32  store data
//   req_pc      in  32  trace tag, echoed on resp_pc
//   resp_valid  out 1   response present
//   resp_ready  in  1   consumer accepts the response
//   resp_rdata  out 32  extended load data, 0 for stores and errors
//   resp_err    out 1   misaligned or out-of-range access
//   resp_pc     out 32  tag of the request being answered
//   init_done   out 1   memory clear complete
// -----------------------------------------------------------------------------
module dm_pipe
    import dm_pipe_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] resp_pc,
    output logic        init_done
);

    localparam int DEPTH  = 1 << ADDR_W;
    // Out-of-range LATENCY values are pinned to the nearest legal bound.
    localparam int STAGES = (LATENCY < LAT_MIN) ? LAT_MIN :
                            (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [31:0]         r_mem [DEPTH];
    logic [STAGES-1:0]   r_vld;
    stage_t              r_stg [STAGES];

    logic                w_run;
    logic                w_stall;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_misalign;
    logic                w_oob;
    logic                w_err;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    stage_t              w_new;
    stage_t              w_last;
    logic [31:0]         w_ext;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_run     = (r_state == ST_RUN);
    assign w_stall   = r_vld[STAGES-1] && !resp_ready;
    assign req_ready = w_run && !w_stall;
    assign w_accept  = req_valid && req_ready;
    assign init_done = w_run;

    // ------------------------------------------------------------------
    // Request decode: word index, error, store byte enables and lanes
    // ------------------------------------------------------------------
    assign w_idx = req_addr[ADDR_W+1:2];
    // Any address bit above the array is an out-of-range access.
    assign w_oob = |(req_addr >> (ADDR_W + 2));
    assign w_err = w_misalign | w_oob;

    always_comb begin
        w_misalign = 1'b0;
        case (req_op)
            OP_LH, OP_LHU, OP_SH: w_misalign = req_addr[0];
            OP_LW, OP_SW:         w_misalign = |req_addr[1:0];
            default:              w_misalign = 1'b0;
        endcase
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = req_wdata;
        case (req_op)
            OP_SB: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            OP_SH: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            OP_SW:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        // Only accepted, error-free stores touch the array.
        if (!w_accept || w_err) begin
            w_be = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Controller: clear every word, then run
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else if (r_state == ST_INIT) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops update together from pre-edge values.
            r_cnt <= r_cnt + ADDR_W'(1);
            if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                r_state <= ST_RUN;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    // NOTE: the array has no reset; it is cleared by the INIT sweep instead,
    // which keeps it mappable onto RAM.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------
    // The read sees the array as left by all earlier edges, i.e. after every
    // previously accepted store; this edge's store lands in parallel.
    always_comb begin
        w_new      = '0;
        w_new.err  = w_err;
        w_new.op   = req_op;
        w_new.lane = req_addr[1:0];
        w_new.pc   = req_pc;
        w_new.word = w_err ? 32'h0 : r_mem[w_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_stg[i] <= '0;
            end
        end else if (!w_stall) begin
            r_vld[0] <= w_accept;
            r_stg[0] <= w_new;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_stg[i] <= r_stg[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output formatting from the last stage (held while stalled)
    // ------------------------------------------------------------------
    assign w_last = r_stg[STAGES-1];

    dm_ext u_ext (
        .i_op   (w_last.op),
        .i_lane (w_last.lane),
        .i_word (w_last.word),
        .o_data (w_ext)
    );

    assign resp_valid = r_vld[STAGES-1];
    assign resp_err   = w_last.err;
    assign resp_rdata = w_last.err ? 32'h0 : w_ext;
    assign resp_pc    = w_last.pc;

endmodule

// File: tb/tb_dm_pipe.sv
// -----------------------------------------------------------------------------
// tb_dm_pipe
// Directed self-checking bench for dm_pipe with ADDR_W=4 (16 words) and
// LATENCY=2. Inputs change 1 time unit after a rising edge; outputs are
// sampled 1-2 time units after a rising edge.
// -----------------------------------------------------------------------------
module tb_dm_pipe;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                           LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] resp_pc;
    logic        init_done;

    int n_total = 0;
    int n_pass  = 0;

    dm_pipe #(.ADDR_W(4), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_pc    (resp_pc),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted; returns 1 unit after
    // the acceptance edge with req_valid dropped.
    task automatic send(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc);
        int waited;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = pc;
        #1;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!req_ready) check("accept_timeout", {31'h0, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
    endtask

    // One request on an empty pipeline with resp_ready=1: response must be
    // absent right after acceptance and present one edge later.
    task automatic single(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc,
                          input logic [31:0] exp_rdata, input logic exp_err);
        send(op, addr, wdata, pc);
        check($sformatf("%s_early", tag), {31'h0, resp_valid}, 32'h0);
        tick();
        check($sformatf("%s_valid", tag), {31'h0, resp_valid}, 32'h1);
        check($sformatf("%s_rdata", tag), resp_rdata, exp_rdata);
        check($sformatf("%s_err", tag), {31'h0, resp_err}, {31'h0, exp_err});
        check($sformatf("%s_pc", tag), resp_pc, pc);
        tick();
    endtask

    initial begin : main
        logic [31:0] got_pc   [3];
        logic [31:0] got_data [3];
        int          got;
        int          seen;
        logic        acc;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = LW;
        req_addr   = '0;
        req_wdata  = '0;
        req_pc     = '0;
        resp_ready = 1'b1;

        // ---------------- reset and clear sweep ----------------
        #3 reset = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_init_done", {31'h0, init_done}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("init_ready_%0d", i), {31'h0, req_ready}, (i == 16) ? 32'h1 : 32'h0);
            check($sformatf("init_done_%0d", i), {31'h0, init_done}, (i == 16) ? 32'h1 : 32'h0);
        end

        single("lw0", LW, 32'h0, 32'h0, 32'h10, 32'h0, 1'b0);

        // ---------------- store word, narrow loads ----------------
        single("sw8", SW, 32'h8, 32'h1234_5678, 32'h14, 32'h0, 1'b0);
        single("lb9", LB, 32'h9, 32'h0, 32'h18, 32'h0000_0056, 1'b0);
        single("lbB", LB, 32'hB, 32'h0, 32'h1C, 32'h0000_0012, 1'b0);
        single("lhA", LH, 32'hA, 32'h0, 32'h20, 32'h0000_1234, 1'b0);

        // ---------------- byte store, sign vs zero extension ----------------
        single("sbC", SB, 32'hC, 32'h0000_00FF, 32'h24, 32'h0, 1'b0);
        single("lbC", LB, 32'hC, 32'h0, 32'h28, 32'hFFFF_FFFF, 1'b0);
        single("lbuC", LBU, 32'hC, 32'h0, 32'h2C, 32'h0000_00FF, 1'b0);

        // ---------------- errors leave memory unchanged ----------------
        single("sw4", SW, 32'h4, 32'hCAFE_F00D, 32'h30, 32'h0, 1'b0);
        single("lw6_err", LW, 32'h6, 32'h0, 32'h34, 32'h0, 1'b1);
        single("sh5_err", SH, 32'h5, 32'h0000_BEEF, 32'h38, 32'h0, 1'b1);
        single("lw40_err", LW, 32'h40, 32'h0, 32'h3C, 32'h0, 1'b1);
        // 0x44 would alias word 1 if the high bits were ignored
        single("sw44_err", SW, 32'h44, 32'hDEAD_BEEF, 32'h40, 32'h0, 1'b1);
        single("lw4", LW, 32'h4, 32'h0, 32'h44, 32'hCAFE_F00D, 1'b0);
        single("lh6", LH, 32'h6, 32'h0, 32'h48, 32'hFFFF_CAFE, 1'b0);
        single("lhu6", LHU, 32'h6, 32'h0, 32'h4C, 32'h0000_CAFE, 1'b0);

        // ---------------- back-to-back loads under backpressure ----------------
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_op     = LW;
        req_addr   = 32'h8;
        req_pc     = 32'h100;
        #1;
        check("bp_ready_a", {31'h0, req_ready}, 32'h1);
        tick();
        req_addr = 32'h4;
        req_pc   = 32'h104;
        #1;
        check("bp_ready_b", {31'h0, req_ready}, 32'h1);
        tick();
        req_addr = 32'hC;
        req_pc   = 32'h108;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_stall_ready_%0d", k), {31'h0, req_ready}, 32'h0);
            check($sformatf("bp_stall_valid_%0d", k), {31'h0, resp_valid}, 32'h1);
            check($sformatf("bp_stall_pc_%0d", k), resp_pc, 32'h100);
            check($sformatf("bp_stall_rdata_%0d", k), resp_rdata, 32'h1234_5678);
            @(posedge clk);
            #2;
        end
        resp_ready = 1'b1;
        #1;
        got = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (resp_valid && resp_ready) begin
                if (got < 3) begin
                    got_pc[got]   = resp_pc;
                    got_data[got] = resp_rdata;
                end
                got++;
            end
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (acc) req_valid = 1'b0;
            #1;
        end
        check("bp_count", got, 32'd3);
        check("bp_pc0", got_pc[0], 32'h100);
        check("bp_pc1", got_pc[1], 32'h104);
        check("bp_pc2", got_pc[2], 32'h108);
        check("bp_data0", got_data[0], 32'h1234_5678);
        check("bp_data1", got_data[1], 32'hCAFE_F00D);
        check("bp_data2", got_data[2], 32'h0000_00FF);

        // ---------------- reset with requests in flight ----------------
        @(posedge clk);
        #1;
        send(LW, 32'h8, 32'h0, 32'h200);
        send(LW, 32'h4, 32'h0, 32'h204);
        check("fl_in_flight", {31'h0, resp_valid}, 32'h1);
        reset = 1'b0;
        #1;
        check("fl_rst_valid", {31'h0, resp_valid}, 32'h0);
        check("fl_rst_ready", {31'h0, req_ready}, 32'h0);
        check("fl_rst_done", {31'h0, init_done}, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (resp_valid) seen++;
            check($sformatf("fl_done_%0d", i), {31'h0, init_done}, (i == 16) ? 32'h1 : 32'h0);
        end
        check("fl_no_resp", seen, 32'd0);
        single("fl_lw8_cleared", LW, 32'h8, 32'h0, 32'h300, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dm_pipe.md
DM_PIPE -- requirements
Module: dm_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address bits; DEPTH = 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, accept-to-response cycles; legal range 1..4.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (reset==0 asserts).
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  request accepted when req_valid && req_ready at clk edge.
REQ-007 SHALL have port req_op  in  3  0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 sb, 6 sh, 7 sw.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data; sb uses [7:0], sh uses [15:0].
REQ-010 SHALL have port req_pc  in  32  trace tag, returned unmodified with the response.
REQ-011 SHALL have port resp_valid  out  1  response present.
REQ-012 SHALL have port resp_ready  in  1  consumer accepts the response.
REQ-013 SHALL have port resp_rdata  out  32  load result, extended per op; 0 for stores and errors.
REQ-014 SHALL have port resp_err  out  1  misaligned or out-of-range access.
REQ-015 SHALL have port resp_pc  out  32  req_pc of the request being answered.
REQ-016 SHALL have port init_done  out  1  memory clear complete.

Function
REQ-017 SHALL implement a two-state FSM: INIT, RUN.
REQ-018 INIT SHALL write 0 to one word per cycle, counter 0..DEPTH-1; after word DEPTH-1 SHALL go to RUN, so init_done rises DEPTH cycles after reset deassertion.
REQ-019 req_ready SHALL be 0 in INIT and whenever the pipeline stalls; otherwise 1.
REQ-020 Stall SHALL be resp_valid && !resp_ready; during a stall all pipeline stages hold their contents.
REQ-021 Each accepted request SHALL produce exactly one response, in acceptance order, LATENCY cycles after acceptance plus any stall cycles.
REQ-022 Stores SHALL update the array at the acceptance edge; sb writes byte addr[1:0], sh writes half addr[1], sw writes the whole word.
REQ-023 Loads SHALL read the array at the acceptance edge, after every store accepted earlier, and carry the data through LATENCY-1 further stages.
REQ-024 Extension: lb/lh sign-extend, lbu/lhu zero-extend; byte lane chosen by addr[1:0], half lane by addr[1].
REQ-025 Error SHALL be lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]!=0, or any nonzero addr[31:ADDR_W+2].
REQ-026 An errored store SHALL leave the memory unchanged; an errored request SHALL return resp_err=1 and resp_rdata=0.
REQ-027 resp_err, resp_rdata and resp_pc SHALL be stable while resp_valid=1 and resp_ready=0.

Reset
REQ-028 Reset assertion SHALL immediately force the FSM to INIT, the counter to 0, all stage valids to 0, resp_valid=0, init_done=0 and req_ready=0.
REQ-029 Reset mid-INIT or mid-traffic SHALL discard in-flight requests and restart the clear from word 0.

Structure
REQ-030 A shared package SHALL hold the op encoding constants, the FSM state type and the LATENCY bounds.
REQ-031 Load extension and lane selection SHALL live in one combinational sub-module, dm_ext.

Verification (ADDR_W=4, LATENCY=2)
REQ-032 Reset release -> req_ready=0 and init_done=0 for 16 cycles, then both 1; lw 0x0 returns 0.
REQ-033 sw 0x8 0x12345678, then lb 0x9, lb 0xB, lh 0xA -> 0x00000056, 0x00000012, 0x00001234, each 2 cycles after acceptance.
REQ-034 sb 0xC 0x000000FF, then lb 0xC, lbu 0xC -> 0xFFFFFFFF, 0x000000FF.
REQ-035 lw 0x6, sh 0x5, lw 0x40 -> all resp_err=1 and rdata 0; then lw 0x4 -> the unchanged prior value.
REQ-036 Three back-to-back lw with resp_ready=0 for 4 cycles -> req_ready=0 during the stall; three in-order responses with correct resp_pc, none lost or duplicated.
REQ-037 Reset pulse with two requests in flight -> no response after reset; init_done returns 16 cycles after release.
